memshare_seq_ctrl: RTL and testbench

MEMSHARE_SEQ_CTRL -- requirements
Module: memshare_seq_ctrl

---
 rtl/memShare_config_pkg.sv | 20 ++
 rtl/memshare_seq_ctrl_if.sv | 40 ++++
 rtl/memshare_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_memshare_seq_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memShare_config_pkg.sv
// Shared configuration for the memShare sequencing logic.
//   MAX_ALLOC_SEQ_NUM : highest allocation-sequence index per operation
//   PIPE_CYCLE_LEN    : clocks per memShare pipeline cycle (2..16)
//   SHIFT_W           : shift-factor width
//   memshare_state_e  : sequencer FSM states
package memShare_config_pkg;

    localparam int unsigned MAX_ALLOC_SEQ_NUM = 3;
    localparam int unsigned PIPE_CYCLE_LEN    = 4;
    localparam int unsigned SHIFT_W           = 5;

    // SHIFT_GEN is the begin clock of a pipeline cycle, HOLD the remaining clocks
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SHIFT_GEN = 2'd1,
        ST_HOLD      = 2'd2,
        ST_DONE      = 2'd3
    } memshare_state_e;

endpackage

// File: rtl/memshare_seq_ctrl_if.sv
// Handshake/data bundle between the memShare requester and the sequencer.
//   master : drives start/abort/alloc_seq_num/shift_factor/share_bound,
//            observes ack/busy/begin/isGtr/seq_idx/shift_val/done
//   slave  : the sequencer side (memshare_seq_ctrl)
interface memshare_seq_ctrl_if #(
    parameter int unsigned MAX_ALLOC_SEQ_NUM = memShare_config_pkg::MAX_ALLOC_SEQ_NUM,
    parameter int unsigned SHIFT_W           = memShare_config_pkg::SHIFT_W
);

    localparam int unsigned IDX_W = $clog2(MAX_ALLOC_SEQ_NUM + 1);

    logic               memShare_start_i;
    logic               memShare_abort_i;
    logic [IDX_W-1:0]   alloc_seq_num_i;
    logic [SHIFT_W-1:0] shift_factor_i;
    logic [SHIFT_W-1:0] share_bound_i;

    logic               start_ack_o;
    logic               scu_memShare_busy_o;
    logic               pipeCycle_begin_o;
    logic               isGtr_o;
    logic [IDX_W-1:0]   seq_idx_o;
    logic [SHIFT_W-1:0] shift_val_o;
    logic               done_o;

    modport master (
        output memShare_start_i, memShare_abort_i, alloc_seq_num_i,
               shift_factor_i, share_bound_i,
        input  start_ack_o, scu_memShare_busy_o, pipeCycle_begin_o,
               isGtr_o, seq_idx_o, shift_val_o, done_o
    );

    modport slave (
        input  memShare_start_i, memShare_abort_i, alloc_seq_num_i,
               shift_factor_i, share_bound_i,
        output start_ack_o, scu_memShare_busy_o, pipeCycle_begin_o,
               isGtr_o, seq_idx_o, shift_val_o, done_o
    );

endinterface

// File: rtl/memshare_seq_ctrl.sv
// memShare operation sequencer: steps through alloc_seq_num+1 pipeline
// cycles of PIPE_CYCLE_LEN clocks, producing the per-cycle isGtr flag and
// effective shift for the skid controller.
//   sys_clk : clock, rising edge
//   rstn    : asynchronous active-low reset
//   bus     : memshare_seq_ctrl_if.slave (start/abort/config in, status out)
module memshare_seq_ctrl
    import memShare_config_pkg::*;
#(
    parameter int unsigned MAX_ALLOC_SEQ_NUM = memShare_config_pkg::MAX_ALLOC_SEQ_NUM,
    parameter int unsigned PIPE_CYCLE_LEN    = memShare_config_pkg::PIPE_CYCLE_LEN,
    parameter int unsigned SHIFT_W           = memShare_config_pkg::SHIFT_W
) (
    input logic                sys_clk,
    input logic                rstn,
    memshare_seq_ctrl_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(MAX_ALLOC_SEQ_NUM + 1);
    localparam int unsigned CNT_W = $clog2(PIPE_CYCLE_LEN);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PIPE_CYCLE_LEN - 2);

    memshare_state_e    state;
    logic [CNT_W-1:0]   hold_cnt;
    logic [IDX_W-1:0]   seq_idx;
    logic [IDX_W-1:0]   last_idx;
    logic               gtr_q;
    logic [SHIFT_W-1:0] shift_q;

    logic               gtr_c;
    logic [SHIFT_W-1:0] shift_c;
    logic [IDX_W-1:0]   alloc_clamped;
    logic               start_ok;

    // Clamp only needed when the index field can encode values above the maximum
    generate
        if ((2 ** IDX_W) - 1 > MAX_ALLOC_SEQ_NUM) begin : g_clamp
            assign alloc_clamped = (bus.alloc_seq_num_i > IDX_W'(MAX_ALLOC_SEQ_NUM))
                                 ? IDX_W'(MAX_ALLOC_SEQ_NUM) : bus.alloc_seq_num_i;
        end else begin : g_no_clamp
            assign alloc_clamped = bus.alloc_seq_num_i;
        end
    endgenerate

    // Abort in the same IDLE cycle suppresses the start
    assign start_ok = (state == ST_IDLE) && bus.memShare_start_i && !bus.memShare_abort_i;
    assign gtr_c    = bus.shift_factor_i > bus.share_bound_i;
    assign shift_c  = gtr_c ? SHIFT_W'(bus.shift_factor_i - bus.share_bound_i)
                            : bus.shift_factor_i;

    // Sequencer state and per-cycle captured values
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            seq_idx  <= '0;
            last_idx <= '0;
            gtr_q    <= 1'b0;
            shift_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state    <= ST_SHIFT_GEN;
                        last_idx <= alloc_clamped;
                        seq_idx  <= '0;
                        hold_cnt <= '0;
                    end
                end
                ST_SHIFT_GEN: begin
                    if (bus.memShare_abort_i) begin
                        state    <= ST_IDLE;
                        seq_idx  <= '0;
                        last_idx <= '0;
                        hold_cnt <= '0;
                        gtr_q    <= 1'b0;
                        shift_q  <= '0;
                    end else begin
                        state    <= ST_HOLD;
                        gtr_q    <= gtr_c;
                        shift_q  <= shift_c;
                        hold_cnt <= '0;
                    end
                end
                ST_HOLD: begin
                    if (bus.memShare_abort_i) begin
                        state    <= ST_IDLE;
                        seq_idx  <= '0;
                        last_idx <= '0;
                        hold_cnt <= '0;
                        gtr_q    <= 1'b0;
                        shift_q  <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (seq_idx < last_idx) begin
                            state   <= ST_SHIFT_GEN;
                            seq_idx <= seq_idx + IDX_W'(1);
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    seq_idx  <= '0;
                    last_idx <= '0;
                    gtr_q    <= 1'b0;
                    shift_q  <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Status outputs decoded from state; begin clock passes the live comparison through
    always_comb begin
        bus.start_ack_o         = start_ok;
        bus.scu_memShare_busy_o = 1'b0;
        bus.pipeCycle_begin_o   = 1'b0;
        bus.isGtr_o             = 1'b0;
        bus.seq_idx_o           = '0;
        bus.shift_val_o         = '0;
        bus.done_o              = 1'b0;
        case (state)
            ST_SHIFT_GEN: begin
                bus.scu_memShare_busy_o = 1'b1;
                bus.pipeCycle_begin_o   = 1'b1;
                bus.isGtr_o             = gtr_c;
                bus.shift_val_o         = shift_c;
                bus.seq_idx_o           = seq_idx;
            end
            ST_HOLD: begin
                bus.scu_memShare_busy_o = 1'b1;
                bus.isGtr_o             = gtr_q;
                bus.shift_val_o         = shift_q;
                bus.seq_idx_o           = seq_idx;
            end
            ST_DONE: begin
                bus.done_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memshare_seq_ctrl.sv
// Self-checking bench for memshare_seq_ctrl: directed scenarios plus random
// traffic, checked every clock against a timeline model of an operation.
module tb_memshare_seq_ctrl;
    import memShare_config_pkg::*;

    localparam int unsigned MAXS = MAX_ALLOC_SEQ_NUM;
    localparam int unsigned P    = PIPE_CYCLE_LEN;
    localparam int unsigned SW   = SHIFT_W;
    localparam int unsigned IW   = $clog2(MAXS + 1);

    logic sys_clk = 1'b0;
    logic rstn    = 1'b0;
    always #5 sys_clk = ~sys_clk;

    memshare_seq_ctrl_if #(.MAX_ALLOC_SEQ_NUM(MAXS), .SHIFT_W(SW)) bus ();

    memshare_seq_ctrl #(
        .MAX_ALLOC_SEQ_NUM(MAXS),
        .PIPE_CYCLE_LEN(P),
        .SHIFT_W(SW)
    ) dut (
        .sys_clk(sys_clk),
        .rstn(rstn),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model: pos = 0 idle, 1..nseq*P busy clocks, nseq*P+1 the done clock
    int            pos   = 0;
    int            nseq  = 0;
    bit            cap_gtr;
    logic [SW-1:0] cap_shift;

    logic          o_ack, o_busy, o_beg, o_gtr, o_done;
    logic [SW-1:0] o_shift;
    logic [IW-1:0] o_seq;

    // One clock: drive inputs after the edge, check at negedge, advance model
    task automatic run_cycle(input logic st, input logic ab, input logic [IW-1:0] al,
                             input logic [SW-1:0] sf, input logic [SW-1:0] sb);
        logic e_ack, e_busy, e_beg, e_gtr, e_done;
        logic [SW-1:0] e_sh;
        logic [IW-1:0] e_seq;
        bit in_busy;
        int n_alloc;
        bus.memShare_start_i = st;
        bus.memShare_abort_i = ab;
        bus.alloc_seq_num_i  = al;
        bus.shift_factor_i   = sf;
        bus.share_bound_i    = sb;
        @(negedge sys_clk);
        in_busy = (pos >= 1) && (pos <= nseq * int'(P));
        e_ack = 1'b0; e_busy = 1'b0; e_beg = 1'b0; e_gtr = 1'b0; e_done = 1'b0;
        e_sh = '0; e_seq = '0;
        if (pos == 0) begin
            e_ack = st && !ab;
        end else if (in_busy) begin
            e_busy = 1'b1;
            e_beg  = ((pos - 1) % int'(P)) == 0;
            e_seq  = IW'((pos - 1) / int'(P));
            if (e_beg) begin
                e_gtr = sf > sb;
                e_sh  = e_gtr ? SW'(sf - sb) : sf;
            end else begin
                e_gtr = cap_gtr;
                e_sh  = cap_shift;
            end
        end else begin
            e_done = 1'b1;
        end
        o_ack = bus.start_ack_o; o_busy = bus.scu_memShare_busy_o;
        o_beg = bus.pipeCycle_begin_o; o_gtr = bus.isGtr_o; o_done = bus.done_o;
        o_shift = bus.shift_val_o; o_seq = bus.seq_idx_o;
        checks += 7;
        if (o_ack !== e_ack) begin
            failures++; $display("FAIL ack pos=%0d got=%b exp=%b", pos, o_ack, e_ack);
        end
        if (o_busy !== e_busy) begin
            failures++; $display("FAIL busy pos=%0d got=%b exp=%b", pos, o_busy, e_busy);
        end
        if (o_beg !== e_beg) begin
            failures++; $display("FAIL begin pos=%0d got=%b exp=%b", pos, o_beg, e_beg);
        end
        if (o_gtr !== e_gtr) begin
            failures++; $display("FAIL isGtr pos=%0d got=%b exp=%b", pos, o_gtr, e_gtr);
        end
        if (o_shift !== e_sh) begin
            failures++; $display("FAIL shift_val pos=%0d got=%0d exp=%0d", pos, o_shift, e_sh);
        end
        if (o_seq !== e_seq) begin
            failures++; $display("FAIL seq_idx pos=%0d got=%0d exp=%0d", pos, o_seq, e_seq);
        end
        if (o_done !== e_done) begin
            failures++; $display("FAIL done pos=%0d got=%b exp=%b", pos, o_done, e_done);
        end
        @(posedge sys_clk);
        #1;
        if (pos == 0) begin
            if (e_ack) begin
                n_alloc = (int'(al) > int'(MAXS)) ? int'(MAXS) : int'(al);
                nseq = n_alloc + 1;
                pos  = 1;
            end
        end else if (in_busy) begin
            if (ab) begin
                pos = 0;
            end else begin
                if (e_beg) begin
                    cap_gtr   = e_gtr;
                    cap_shift = e_sh;
                end
                pos++;
            end
        end else begin
            pos = 0;
        end
    endtask

    task automatic idle_cycle();
        run_cycle(1'b0, 1'b0, '0, SW'($urandom), SW'($urandom));
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        bus.memShare_start_i = 1'b1;
        bus.memShare_abort_i = 1'b0;
        bus.alloc_seq_num_i  = '0;
        bus.shift_factor_i   = SW'(9);
        bus.share_bound_i    = SW'(2);
        rstn = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        outs = {bus.scu_memShare_busy_o, bus.pipeCycle_begin_o, bus.isGtr_o,
                bus.done_o, (bus.shift_val_o != '0), (bus.seq_idx_o != '0), 1'b0};
        checks++;
        if (outs !== 7'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=0000000", outs);
        end
        bus.memShare_start_i = 1'b0;
        @(posedge sys_clk);
        #1;
        rstn = 1'b1;
        pos  = 0;
        repeat (2) idle_cycle();
    endtask

    task automatic test_basic_timing();
        int busy_cnt = 0;
        int done_at  = -1;
        int beg_mask = 0;
        run_cycle(1'b1, 1'b0, IW'(2), SW'(7), SW'(3));
        for (int c = 1; c < 16; c++) begin
            run_cycle(1'b0, 1'b0, '0, SW'(7), SW'(3));
            if (o_busy) busy_cnt++;
            if (o_done) done_at = c;
            if (o_beg)  beg_mask |= (1 << c);
        end
        checks += 3;
        if (busy_cnt != 12) begin
            failures++; $display("FAIL basic_busy_len got=%0d exp=12", busy_cnt);
        end
        if (done_at != 13) begin
            failures++; $display("FAIL basic_done_cycle got=%0d exp=13", done_at);
        end
        if (beg_mask != ((1 << 1) | (1 << 5) | (1 << 9))) begin
            failures++; $display("FAIL basic_begin_cycles got=%h exp=%h", beg_mask,
                                 (1 << 1) | (1 << 5) | (1 << 9));
        end
    endtask

    task automatic test_per_sequence();
        int sf_t[3] = '{9, 2, 6};
        int sb_t[3] = '{4, 6, 6};
        int eg_t[3] = '{1, 0, 0};
        int es_t[3] = '{5, 2, 6};
        int cur, s, ph;
        run_cycle(1'b1, 1'b0, IW'(2), SW'(0), SW'(0));
        for (int c = 1; c < 15; c++) begin
            cur = pos;
            s   = (cur - 1) / int'(P);
            ph  = (cur - 1) % int'(P);
            if (cur >= 1 && s < 3 && ph == 0)
                run_cycle(1'b0, 1'b0, '0, SW'(sf_t[s]), SW'(sb_t[s]));
            else
                idle_cycle();
            if (cur >= 1 && s < 3 && ph == 2) begin
                checks += 2;
                if (int'(o_gtr) != eg_t[s]) begin
                    failures++; $display("FAIL seq%0d_isGtr_held got=%b exp=%0d", s, o_gtr, eg_t[s]);
                end
                if (int'(o_shift) != es_t[s]) begin
                    failures++; $display("FAIL seq%0d_shift_held got=%0d exp=%0d", s, o_shift, es_t[s]);
                end
            end
        end
    endtask

    task automatic test_boundary();
        int cur, ph, s;
        run_cycle(1'b1, 1'b0, IW'(1), SW'(0), SW'(0));
        for (int c = 1; c < 11; c++) begin
            cur = pos;
            s   = (cur - 1) / int'(P);
            ph  = (cur - 1) % int'(P);
            if (cur >= 1 && s == 0 && ph == 0)      run_cycle(1'b0, 1'b0, '0, SW'(3), SW'(20));
            else if (cur >= 1 && s == 1 && ph == 0) run_cycle(1'b0, 1'b0, '0, SW'(20), SW'(3));
            else                                    idle_cycle();
            if (cur >= 1 && s < 2 && ph == 1) begin
                checks += 2;
                if (o_gtr !== (s == 1)) begin
                    failures++; $display("FAIL bound%0d_isGtr got=%b exp=%0d", s, o_gtr, s == 1);
                end
                if (int'(o_shift) != ((s == 1) ? 17 : 3)) begin
                    failures++; $display("FAIL bound%0d_shift got=%0d exp=%0d", s, o_shift,
                                         (s == 1) ? 17 : 3);
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        int acks    = 0;
        int done_at = -1;
        run_cycle(1'b1, 1'b0, IW'(1), SW'(5), SW'(1));
        for (int c = 1; c < 12; c++) begin
            run_cycle(pos >= 1 && pos <= 2 * int'(P), 1'b0, IW'($urandom), SW'($urandom), SW'($urandom));
            if (o_ack && c <= 2 * int'(P) + 1) acks++;
            if (o_done) done_at = c;
        end
        checks += 2;
        if (acks != 0) begin
            failures++; $display("FAIL busy_start_acks got=%0d exp=0", acks);
        end
        if (done_at != 2 * int'(P) + 1) begin
            failures++; $display("FAIL busy_start_done_cycle got=%0d exp=%0d", done_at, 2 * int'(P) + 1);
        end
    endtask

    task automatic test_abort();
        int saw_done = 0;
        run_cycle(1'b1, 1'b0, IW'(2), SW'(7), SW'(3));
        while (pos != 1 + int'(P) + 2) idle_cycle();
        run_cycle(1'b0, 1'b1, '0, SW'($urandom), SW'($urandom));
        for (int c = 0; c < 6; c++) begin
            idle_cycle();
            if (o_done) saw_done++;
            if (c == 0) begin
                checks++;
                if (o_busy !== 1'b0) begin
                    failures++; $display("FAIL abort_busy_next got=%b exp=0", o_busy);
                end
            end
        end
        checks++;
        if (saw_done != 0) begin
            failures++; $display("FAIL abort_done_pulses got=%0d exp=0", saw_done);
        end
        run_cycle(1'b1, 1'b1, IW'(1), SW'(4), SW'(1));
        checks++;
        if (o_ack !== 1'b0) begin
            failures++; $display("FAIL abort_start_same_cycle_ack got=%b exp=0", o_ack);
        end
        repeat (2) idle_cycle();
    endtask

    task automatic test_reset_mid();
        logic [IW-1:0] al7;
        logic [6:0] outs;
        int begins = 0;
        run_cycle(1'b1, 1'b0, IW'(3), SW'(7), SW'(2));
        idle_cycle();
        idle_cycle();
        #1;
        rstn = 1'b0;
        #1;
        outs = {bus.scu_memShare_busy_o, bus.pipeCycle_begin_o, bus.isGtr_o,
                bus.done_o, (bus.shift_val_o != '0), (bus.seq_idx_o != '0), bus.start_ack_o};
        checks++;
        if (outs !== 7'b0) begin
            failures++; $display("FAIL async_reset_outputs got=%b exp=0000000", outs);
        end
        @(posedge sys_clk);
        #1;
        rstn = 1'b1;
        pos  = 0;
        repeat (3) idle_cycle();
        al7 = IW'(7);
        run_cycle(1'b1, 1'b0, al7, SW'(1), SW'(1));
        for (int c = 0; c < 4 * int'(P) + 3; c++) begin
            idle_cycle();
            if (o_beg) begins++;
        end
        checks++;
        if (begins != 4) begin
            failures++; $display("FAIL clamp_sequences got=%0d exp=4", begins);
        end
    endtask

    task automatic test_random();
        logic [SW-1:0] sf, sb;
        for (int c = 0; c < 800; c++) begin
            sf = SW'($urandom);
            sb = ($urandom_range(0, 3) == 0) ? sf : SW'($urandom);
            run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                      IW'($urandom), sf, sb);
        end
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_per_sequence();
        test_boundary();
        test_start_while_busy();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
